// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data memory arbiter, its two requesters and the memory.
// The slave view belongs to the arbiter; the master view drives requests and memory read data.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_a;
  logic              ack_b;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_read_data,
    output ack_a, ack_b, rdata, err, mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_read_data,
    input  ack_a, ack_b, rdata, err, mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-port word memory between a CPU port (A) and a DMA port (B).
// One transaction in flight: IDLE -> ACCESS -> RESP, rejected accesses skip ACCESS.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 4096,
  parameter bit          RR_INIT   = 1'b0
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(MEM_BYTES - 4);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;

  logic              any_req;
  logic              sel_b;
  logic              sel_we;
  logic              sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Winner selection and access check, evaluated every cycle but only used in StIdle.
  always_comb begin
    any_req   = bus.req_a | bus.req_b;
    sel_b     = (bus.req_a && bus.req_b) ? rr_q : bus.req_b;
    sel_we    = sel_b ? bus.we_b : bus.we_a;
    sel_addr  = sel_b ? bus.addr_b : bus.addr_a;
    sel_wdata = sel_b ? bus.wdata_b : bus.wdata_a;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > LastWord);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_q     <= RR_INIT;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = sel_err ? StResp : StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rr_d     = rr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      StIdle: begin
        rdata_d = '0;
        if (any_req) begin
          owner_d = sel_b;
          we_d    = sel_we;
          err_d   = sel_err;
          // Rejected accesses leave the memory-facing address/data untouched.
          if (!sel_err) begin
            maddr_d  = sel_addr;
            mwdata_d = sel_wdata;
          end
        end
      end
      StAccess: rdata_d = we_q ? '0 : bus.mem_read_data;
      StResp:   rr_d = ~owner_q;
      default:  ;
    endcase
  end

  always_comb begin
    bus.mem_read       = (state_q == StAccess) && !we_q;
    bus.mem_write      = (state_q == StAccess) && we_q;
    bus.mem_address    = maddr_q;
    bus.mem_write_data = mwdata_q;
    bus.ack_a          = (state_q == StResp) && !owner_q;
    bus.ack_b          = (state_q == StResp) && owner_q;
    bus.err            = (state_q == StResp) && err_q;
    bus.rdata          = rdata_q;
  end

endmodule
